// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: state codes,
// ALU function codes, opcode/funct constants and datapath mux selects.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMMEX    = 4'd9,
    S_IMMWB    = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // ALU function codes; 3 is deliberately unused
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every opcode the controller knows how to sequence
  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LW, OP_SW: is_legal = 1'b1;
      default:                       is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU function and immediate-extension decode. Funct selects the operation
// for R-type execute; the opcode selects it for immediate arithmetic.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [3:0] State,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  output logic [2:0] ALUOP,
  output logic       ExtOp
);

  // ALU operation per state; address and PC arithmetic all use add
  always_comb begin
    ALUOP = ALU_ADD;
    case (State)
      S_EXECUTE: begin
        case (Funct)
          FN_SUB:  ALUOP = ALU_SUB;
          FN_AND:  ALUOP = ALU_AND;
          FN_OR:   ALUOP = ALU_OR;
          FN_SLT:  ALUOP = ALU_SLT;
          default: ALUOP = ALU_ADD;
        endcase
      end
      S_BRANCH: ALUOP = ALU_SUB;
      S_IMMEX: begin
        case (Opcode)
          OP_SLTI: ALUOP = ALU_SLT;
          OP_ANDI: ALUOP = ALU_AND;
          OP_ORI:  ALUOP = ALU_OR;
          default: ALUOP = ALU_ADD;
        endcase
      end
      default: ALUOP = ALU_ADD;
    endcase
  end

  // Logical immediates zero-extend; held through writeback as well
  always_comb begin
    ExtOp = 1'b0;
    if ((State == S_IMMEX) || (State == S_IMMWB))
      ExtOp = (Opcode == OP_ANDI) || (Opcode == OP_ORI);
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   FETCH    | read instruction, load IR, PC <= PC + 4
//   DECODE   | read registers, precompute branch target
//   MEMADR   | compute load/store address
//   MEMREAD  | read data memory into MDR
//   MEMWB    | write MDR to rt
//   MEMWRITE | write B to data memory
//   EXECUTE  | R-type ALU operation
//   ALUWB    | write ALUOut to rd
//   BRANCH   | compare A and B, conditionally load target
//   IMMEX    | immediate ALU operation
//   IMMWB    | write ALUOut to rt
//   JUMP     | load jump target into PC
//   12..15   | unreachable; all enables low, back to FETCH
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       ZeroFlag,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOP,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t state_q;
  state_t state_d;

  assign State = state_q;

  alu_decoder u_alu_decoder (
    .State  (state_q),
    .Opcode (Opcode),
    .Funct  (Funct),
    .ALUOP  (ALUOP),
    .ExtOp  (ExtOp)
  );

  // State register: the only storage in the controller
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:                          state_d = S_EXECUTE;
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          OP_J:                              state_d = S_JUMP;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_IMMEX:    state_d = S_IMMWB;
      S_IMMWB:    state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs plus the branch decision; enables forced low in reset
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_B;
    PCSource = PCSRC_ALU;
    Illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        IRWrite  = 1'b1;
        PCWrite  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        PCSource = PCSRC_ALU;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        Illegal = !is_legal(Opcode);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_B;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_B;
        PCSource = PCSRC_ALUOUT;
        PCWrite  = ((Opcode == OP_BEQ) && ZeroFlag) ||
                   ((Opcode == OP_BNE) && !ZeroFlag);
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_IMMWB: begin
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: begin
      end
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multi-cycle MIPS control FSM.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       ZeroFlag;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic       RegDst, RegWrite, ALUSrcA, ExtOp, Illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOP;
  logic [3:0] State;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk      (clk),
    .reset    (reset),
    .Opcode   (Opcode),
    .Funct    (Funct),
    .ZeroFlag (ZeroFlag),
    .PCWrite  (PCWrite),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .MemtoReg (MemtoReg),
    .RegDst   (RegDst),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ExtOp    (ExtOp),
    .PCSource (PCSource),
    .ALUOP    (ALUOP),
    .Illegal  (Illegal),
    .State    (State)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // enables packed as {PCWrite,MemRead,MemWrite,IRWrite,RegWrite,Illegal}
  function automatic logic [5:0] enables();
    return {PCWrite, MemRead, MemWrite, IRWrite, RegWrite, Illegal};
  endfunction

  task automatic chk_fetch(input string tag);
    chk({tag, "_state"}, State, 4'd0);
    chk({tag, "_en"}, enables(), 6'b110100);
    chk({tag, "_srcb"}, ALUSrcB, 2'b01);
    chk({tag, "_pcsrc_aluop"}, {PCSource, ALUOP}, {2'b00, 3'd0});
  endtask

  // from FETCH, step into DECODE and check it
  task automatic to_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
    Opcode = op;
    Funct  = fn;
    tick();
    chk({tag, "_dec_state"}, State, 4'd1);
    chk({tag, "_dec_srcb_aluop"}, {ALUSrcB, ALUOP}, {2'b11, 3'd0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    Opcode = 6'h00;
    Funct = 6'h20;
    ZeroFlag = 1'b0;

    // reset held three cycles
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_state", State, 4'd0);
      chk("rst_en", enables(), 6'b000000);
      chk("rst_srcb", ALUSrcB, 2'b01);
      tick();
    end
    reset = 1'b0;
    #1;
    chk_fetch("rel");

    // R-type slt
    to_decode("slt", 6'h00, 6'h2A);
    tick();
    chk("slt_ex_state", State, 4'd6);
    chk("slt_ex_aluop", ALUOP, 3'd5);
    chk("slt_ex_src", {ALUSrcA, ALUSrcB}, 3'b100);
    tick();
    chk("slt_wb_state", State, 4'd7);
    chk("slt_wb_ctl", {RegWrite, RegDst, MemtoReg}, 3'b110);
    tick();
    chk_fetch("slt_end");

    // R-type sub
    to_decode("sub", 6'h00, 6'h22);
    tick();
    chk("sub_ex_state", State, 4'd6);
    chk("sub_ex_aluop", ALUOP, 3'd1);
    tick();
    chk("sub_wb_state", State, 4'd7);
    tick();
    chk_fetch("sub_end");

    // unknown funct executes as add without Illegal
    to_decode("fnx", 6'h00, 6'h3F);
    chk("fnx_dec_illegal", Illegal, 1'b0);
    tick();
    chk("fnx_ex_aluop", ALUOP, 3'd0);
    tick();
    tick();
    chk_fetch("fnx_end");

    // lw
    to_decode("lw", 6'h23, 6'h00);
    tick();
    chk("lw_adr_state", State, 4'd2);
    chk("lw_adr_ctl", {ALUSrcA, ALUSrcB, ALUOP}, {1'b1, 2'b10, 3'd0});
    tick();
    chk("lw_rd_state", State, 4'd3);
    chk("lw_rd_ctl", {MemRead, IorD, MemWrite}, 3'b110);
    tick();
    chk("lw_wb_state", State, 4'd4);
    chk("lw_wb_ctl", {RegWrite, MemtoReg, RegDst}, 3'b110);
    tick();
    chk_fetch("lw_end");

    // sw
    to_decode("sw", 6'h2B, 6'h00);
    tick();
    chk("sw_adr_state", State, 4'd2);
    tick();
    chk("sw_wr_state", State, 4'd5);
    chk("sw_wr_ctl", {MemWrite, IorD, MemRead, RegWrite}, 4'b1100);
    tick();
    chk_fetch("sw_end");

    // beq: PCWrite follows ZeroFlag combinationally
    to_decode("beq", 6'h04, 6'h00);
    tick();
    chk("beq_state", State, 4'd8);
    chk("beq_ctl", {ALUSrcA, ALUSrcB, ALUOP, PCSource}, {1'b1, 2'b00, 3'd1, 2'b01});
    ZeroFlag = 1'b1;
    #1;
    chk("beq_z1_pcw", PCWrite, 1'b1);
    ZeroFlag = 1'b0;
    #1;
    chk("beq_z0_pcw", PCWrite, 1'b0);
    tick();
    chk_fetch("beq_end");

    // bne: inverse condition
    to_decode("bne", 6'h05, 6'h00);
    tick();
    chk("bne_state", State, 4'd8);
    ZeroFlag = 1'b1;
    #1;
    chk("bne_z1_pcw", PCWrite, 1'b0);
    ZeroFlag = 1'b0;
    #1;
    chk("bne_z0_pcw", PCWrite, 1'b1);
    ZeroFlag = 1'b1;
    tick();
    chk_fetch("bne_end_zignored");
    ZeroFlag = 1'b0;

    // ori
    to_decode("ori", 6'h0D, 6'h00);
    chk("ori_dec_ext", ExtOp, 1'b0);
    tick();
    chk("ori_ex_state", State, 4'd9);
    chk("ori_ex_ctl", {ALUOP, ExtOp, ALUSrcA, ALUSrcB}, {3'd4, 1'b1, 1'b1, 2'b10});
    tick();
    chk("ori_wb_state", State, 4'd10);
    chk("ori_wb_ctl", {RegWrite, RegDst, MemtoReg, ExtOp}, 4'b1001);
    tick();
    chk_fetch("ori_end");

    // andi, slti, addi in IMMEX
    to_decode("andi", 6'h0C, 6'h00);
    tick();
    chk("andi_ex", {ALUOP, ExtOp}, {3'd2, 1'b1});
    tick();
    tick();
    to_decode("slti", 6'h0A, 6'h00);
    tick();
    chk("slti_ex", {ALUOP, ExtOp}, {3'd5, 1'b0});
    tick();
    tick();
    to_decode("addi", 6'h08, 6'h00);
    tick();
    chk("addi_ex", {ALUOP, ExtOp}, {3'd0, 1'b0});
    tick();
    chk("addi_wb", {State, ExtOp}, {4'd10, 1'b0});
    tick();
    chk_fetch("imm_end");

    // jump
    to_decode("j", 6'h02, 6'h00);
    tick();
    chk("j_state", State, 4'd11);
    chk("j_ctl", {PCWrite, PCSource}, {1'b1, 2'b10});
    tick();
    chk_fetch("j_end");

    // illegal opcode
    to_decode("ill", 6'h3F, 6'h00);
    chk("ill_pulse", Illegal, 1'b1);
    tick();
    chk_fetch("ill_end");
    chk("ill_clear", Illegal, 1'b0);

    // async reset during MEMREAD
    to_decode("arst", 6'h23, 6'h00);
    tick();
    tick();
    chk("arst_pre_state", State, 4'd3);
    chk("arst_pre_rd", MemRead, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", State, 4'd0);
    chk("arst_en", enables(), 6'b000000);
    chk("arst_srcb", ALUSrcB, 2'b01);
    tick();
    chk("arst_hold_state", State, 4'd0);
    reset = 1'b0;
    #1;
    chk_fetch("arst_rel");
    to_decode("arst_resume", 6'h00, 6'h24);
    tick();
    chk("arst_resume_and", {State, ALUOP}, {4'd6, 3'd2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
